// File: rtl/fpu_issue_scheduler.sv
// FPU issue scheduler: one shift register of writeback reservations drives the
// port, RAW and WAW hazard checks and the retiring writeback strobe.
module fpu_issue_scheduler #(
  parameter int MAXLAT = 4,
  parameter int RW     = 5,
  parameter int LW     = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          issue_valid,
  input  logic          issue_wen,
  input  logic [RW-1:0] issue_rd,
  input  logic [RW-1:0] issue_rs1,
  input  logic [RW-1:0] issue_rs2,
  input  logic          use_rs1,
  input  logic          use_rs2,
  input  logic [LW-1:0] issue_lat,
  input  logic          flush,
  output logic          hazard,
  output logic          issue_acc,
  output logic          lat_err,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [LW-1:0] inflight
);

  logic          slot_v_q  [1:MAXLAT];
  logic [RW-1:0] slot_rd_q [1:MAXLAT];
  logic          slot_v_d  [1:MAXLAT];
  logic [RW-1:0] slot_rd_d [1:MAXLAT];
  logic [LW-1:0] inflight_d;
  logic [LW-1:0] inflight_q;
  logic          lat_err_q;
  logic          lat_ok;
  logic          port_hit;
  logic          raw_hit;
  logic          waw_hit;

  always_comb begin
    lat_ok   = (issue_lat != '0) && (issue_lat <= LW'(MAXLAT));
    port_hit = 1'b0;
    raw_hit  = 1'b0;
    waw_hit  = 1'b0;
    for (int k = 1; k <= MAXLAT; k++) begin
      if (slot_v_q[k]) begin
        // s[1] retires this cycle and is forwarded downstream, so RAW skips it
        if (k >= 2 && ((use_rs1 && slot_rd_q[k] == issue_rs1) ||
                       (use_rs2 && slot_rd_q[k] == issue_rs2)))
          raw_hit = 1'b1;
        if (issue_wen && k == int'(issue_lat) + 1)
          port_hit = 1'b1;
        if (issue_wen && k >= int'(issue_lat) + 1 && slot_rd_q[k] == issue_rd)
          waw_hit = 1'b1;
      end
    end
    hazard    = issue_valid & lat_ok & (port_hit | raw_hit | waw_hit);
    issue_acc = issue_valid & lat_ok & ~hazard & ~flush;
  end

  always_comb begin
    for (int k = 1; k < MAXLAT; k++) begin
      slot_v_d[k]  = slot_v_q[k+1];
      slot_rd_d[k] = slot_rd_q[k+1];
    end
    slot_v_d[MAXLAT]  = 1'b0;
    slot_rd_d[MAXLAT] = '0;
    // The new reservation lands where the shift would otherwise fill
    for (int k = 1; k <= MAXLAT; k++) begin
      if (issue_acc && issue_wen && k == int'(issue_lat)) begin
        slot_v_d[k]  = 1'b1;
        slot_rd_d[k] = issue_rd;
      end
    end
    inflight_d = '0;
    for (int k = 1; k <= MAXLAT; k++)
      inflight_d = inflight_d + LW'(slot_v_d[k]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= MAXLAT; k++) begin
        slot_v_q[k]  <= 1'b0;
        slot_rd_q[k] <= '0;
      end
      inflight_q <= '0;
      lat_err_q  <= 1'b0;
    end else begin
      for (int k = 1; k <= MAXLAT; k++) begin
        slot_v_q[k]  <= slot_v_d[k];
        slot_rd_q[k] <= slot_rd_d[k];
      end
      inflight_q <= inflight_d;
      lat_err_q  <= issue_valid & ~lat_ok;
    end
  end

  assign wb_valid = slot_v_q[1];
  assign wb_rd    = slot_rd_q[1];
  assign inflight = inflight_q;
  assign lat_err  = lat_err_q;

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Bench for fpu_issue_scheduler: directed vector table, hand sequences for RAW and
// reset, then random traffic against a model built on a list of pending writebacks.
module tb_fpu_issue_scheduler;
  localparam int MAXLAT = 4;
  localparam int RW     = 5;
  localparam int LW     = 3;

  logic          clk, rstn;
  logic          issue_valid, issue_wen, use_rs1, use_rs2, flush;
  logic [RW-1:0] issue_rd, issue_rs1, issue_rs2;
  logic [LW-1:0] issue_lat;
  logic          hazard, issue_acc, lat_err, wb_valid;
  logic [RW-1:0] wb_rd;
  logic [LW-1:0] inflight;

  fpu_issue_scheduler #(.MAXLAT(MAXLAT), .RW(RW), .LW(LW)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .issue_lat(issue_lat), .flush(flush),
    .hazard(hazard), .issue_acc(issue_acc), .lat_err(lat_err),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v, wen; logic [4:0] rd, rs1, rs2; logic u1, u2; logic [2:0] lat; logic fl;
    logic eh, ea, ewv; logic [4:0] ewrd; logic [2:0] einf; logic ele;
  } vec_t;

  typedef struct { int due; logic [4:0] rd; } pend_t;

  vec_t  tbl[$];
  pend_t pend[$];
  int    cyc, n_cmp, n_err;
  logic  le_prev;

  function automatic vec_t mk(logic v, logic wen, logic [4:0] rd, logic [2:0] lat, logic fl,
                              logic eh, logic ea, logic ewv, logic [4:0] ewrd,
                              logic [2:0] einf, logic ele);
    vec_t r;
    r.v = v; r.wen = wen; r.rd = rd; r.rs1 = '0; r.rs2 = '0; r.u1 = 1'b0; r.u2 = 1'b0;
    r.lat = lat; r.fl = fl; r.eh = eh; r.ea = ea; r.ewv = ewv; r.ewrd = ewrd;
    r.einf = einf; r.ele = ele;
    return r;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(logic v, logic wen, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                       logic u1, logic u2, logic [2:0] lat, logic fl);
    issue_valid = v; issue_wen = wen; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    use_rs1 = u1; use_rs2 = u2; issue_lat = lat; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Slot k in cycle cyc is the pending write due at cyc+k-1.
  task automatic model_step();
    logic lat_ok, raw, port, waw, eh, ea, ewv;
    logic [4:0] ewrd;
    int cnt;
    lat_ok = (issue_lat >= 1) && (int'(issue_lat) <= MAXLAT);
    raw = 0; port = 0; waw = 0; ewv = 0; ewrd = 0; cnt = 0;
    foreach (pend[i]) begin
      if (pend[i].due >= cyc + 1 &&
          ((use_rs1 && pend[i].rd == issue_rs1) || (use_rs2 && pend[i].rd == issue_rs2)))
        raw = 1;
      if (issue_wen && pend[i].due == cyc + int'(issue_lat)) port = 1;
      if (issue_wen && pend[i].rd == issue_rd && pend[i].due >= cyc + int'(issue_lat)) waw = 1;
      if (pend[i].due == cyc) begin ewv = 1; ewrd = pend[i].rd; end
      cnt++;
    end
    eh = issue_valid & lat_ok & (raw | port | waw);
    ea = issue_valid & lat_ok & ~eh & ~flush;
    chk("m_hazard", 8'(hazard), 8'(eh));
    chk("m_acc", 8'(issue_acc), 8'(ea));
    chk("m_wb_valid", 8'(wb_valid), 8'(ewv));
    if (ewv) chk("m_wb_rd", 8'(wb_rd), 8'(ewrd));
    chk("m_inflight", 8'(inflight), 8'(cnt));
    chk("m_lat_err", 8'(lat_err), 8'(le_prev));
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].due == cyc) pend.delete(i);
    if (ea && issue_wen) pend.push_back('{due: cyc + int'(issue_lat), rd: issue_rd});
    le_prev = issue_valid & ~lat_ok;
    cyc++;
  endtask

  task automatic tick();
    #1;
    model_step();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; le_prev = 0;
    rstn = 1'b0;
    idle();

    // c0 latency; c5 port conflict; c11 WAW; c17 flush; c18 illegal lat
    tbl.push_back(mk(1,1,3,4,0, 0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,3,1,0));
    tbl.push_back(mk(1,1,1,4,0, 0,1,0,0,0,0));
    tbl.push_back(mk(1,1,2,3,0, 1,0,0,0,1,0));
    tbl.push_back(mk(1,1,2,3,0, 0,1,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,2,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,2,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,2,1,0));
    tbl.push_back(mk(1,1,7,4,0, 0,1,0,0,0,0));
    tbl.push_back(mk(1,1,7,1,0, 1,0,0,0,1,0));
    tbl.push_back(mk(1,1,7,1,0, 1,0,0,0,1,0));
    tbl.push_back(mk(1,1,7,1,0, 1,0,0,0,1,0));
    tbl.push_back(mk(1,1,7,1,0, 0,1,1,7,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,7,1,0));
    tbl.push_back(mk(1,1,9,2,1, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,9,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));

    @(negedge clk);
    #1;
    chk("rst_wb_valid", 8'(wb_valid), 8'd0);
    chk("rst_inflight", 8'(inflight), 8'd0);
    chk("rst_lat_err", 8'(lat_err), 8'd0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].wen, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
            tbl[i].u1, tbl[i].u2, tbl[i].lat, tbl[i].fl);
      #1;
      chk($sformatf("t%0d_hazard", i), 8'(hazard), 8'(tbl[i].eh));
      chk($sformatf("t%0d_acc", i), 8'(issue_acc), 8'(tbl[i].ea));
      chk($sformatf("t%0d_wb_valid", i), 8'(wb_valid), 8'(tbl[i].ewv));
      if (tbl[i].ewv) chk($sformatf("t%0d_wb_rd", i), 8'(wb_rd), 8'(tbl[i].ewrd));
      chk($sformatf("t%0d_inflight", i), 8'(inflight), 8'(tbl[i].einf));
      chk($sformatf("t%0d_lat_err", i), 8'(lat_err), 8'(tbl[i].ele));
      model_step();
      @(negedge clk);
    end

    // RAW: producer rd5 lat3 blocks a reader until it sits in s[1]
    drive(1, 1, 5, 0, 0, 0, 0, 3, 0); tick();
    drive(1, 0, 0, 5, 0, 1, 0, 1, 0);
    #1; chk("raw_t1_hazard", 8'(hazard), 8'd1); model_step(); @(negedge clk);
    #1; chk("raw_t2_hazard", 8'(hazard), 8'd1); model_step(); @(negedge clk);
    #1; chk("raw_t3_acc", 8'(issue_acc), 8'd1); model_step(); @(negedge clk);
    drive(1, 1, 5, 0, 0, 0, 0, 3, 0); tick();
    drive(1, 0, 0, 5, 5, 0, 0, 1, 0);
    #1; chk("raw_nouse_acc", 8'(issue_acc), 8'd1); model_step(); @(negedge clk);
    idle();
    repeat (5) tick();

    // Reset mid-stream with all four slots reserved
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(10 + i), 0, 0, 0, 0, 4, 0);
      tick();
    end
    idle();
    #1;
    chk("full_inflight", 8'(inflight), 8'd4);
    chk("full_wb_valid", 8'(wb_valid), 8'd1);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_wb_valid", 8'(wb_valid), 8'd0);
    chk("midrst_inflight", 8'(inflight), 8'd0);
    pend.delete();
    le_prev = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1; chk("postrst_wb_valid", 8'(wb_valid), 8'd0); model_step(); @(negedge clk);
    end

    // Random traffic against the pending-write model
    for (int i = 0; i < 800; i++) begin
      logic [2:0] lat;
      if ($urandom_range(0, 7) == 0) lat = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
      else lat = 3'($urandom_range(1, 4));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat,
            $urandom_range(0, 9) == 0);
      tick();
    end
    idle();
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
